// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal sync multi-port responder.
//   fractal_sync_rsp_state_e : per-port handshake state (IDLE, WAIT, RSP)
//   popcnt_width(n)          : bits needed to hold a count from 0 to n
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } fractal_sync_rsp_state_e;

  function automatic int unsigned popcnt_width(input int unsigned n);
    return $clog2(n + 32'd1);
  endfunction

endpackage

// File: rtl/fractal_sync_mp_rsp_chk.sv
// Parameter and run-time sanity checks for the sync responder.
//   clk, rst_n : clock, asynchronous active-low reset
//   alloc_fail : an unpaired request found no free CAM line this cycle
module fractal_sync_mp_rsp_chk #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned N_LINES = 2
) (
  input logic clk,
  input logic rst_n,
  input logic alloc_fail
);

  if (N_PORTS < 2) begin : g_bad_ports
    $fatal(1, "fractal_sync_mp_rsp: N_PORTS must be at least 2");
  end

  if (N_LINES < N_PORTS) begin : g_bad_lines
    $fatal(1, "fractal_sync_mp_rsp: N_LINES must be at least N_PORTS");
  end

  // With one outstanding request per port and N_LINES >= N_PORTS this can
  // only fire if the occupancy bookkeeping is broken.
  a_alloc_ok: assert property (@(posedge clk) disable iff (!rst_n) !alloc_fail)
    else $error("fractal_sync_mp_rsp: no free CAM line for an unpaired request");

endmodule

// File: rtl/fractal_sync_mp_rsp_line.sv
// One CAM line of the sync responder. It parks the signature and origin port
// of an unpaired request and compares its signature against every port.
//   clk, rst_n    : clock, asynchronous active-low reset
//   alloc         : park alloc_sig / alloc_origin in this line (line is free)
//   release_line  : invalidate the line (its pair has completed)
//   cmp_sig       : per-port request signatures to compare against
//   valid, origin : line occupancy and the parked port index
//   match         : per-port hit (valid and signature equal)
module fractal_sync_mp_rsp_line #(
  parameter int unsigned SIG_WIDTH = 1,
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned IDX_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc,
  input  logic [SIG_WIDTH-1:0] alloc_sig,
  input  logic [IDX_WIDTH-1:0] alloc_origin,
  input  logic                 release_line,
  input  logic [SIG_WIDTH-1:0] cmp_sig [N_PORTS],
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] origin,
  output logic [N_PORTS-1:0]   match
);

  logic [SIG_WIDTH-1:0] sig_q;

  // Line storage: allocation and release are mutually exclusive by construction
  // (alloc only targets free lines, release only hits valid ones).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      sig_q  <= '0;
      origin <= '0;
    end else if (alloc) begin
      valid  <= 1'b1;
      sig_q  <= alloc_sig;
      origin <= alloc_origin;
    end else if (release_line) begin
      valid  <= 1'b0;
    end else begin
      valid  <= valid;
    end
  end

  // Per-port signature comparison against the parked entry.
  always_comb begin
    match = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      match[p] = valid && (sig_q == cmp_sig[p]);
    end
  end

endmodule

// File: rtl/fractal_sync_mp_rsp.sv
// Multi-port pairwise sync responder. The first request for a signature is
// parked in a CAM line; the second request with the same signature frees the
// line and both participants get a response carrying that signature.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   req_valid_i/ready_o : per-port request handshake, ready only in IDLE
//   req_sig_i           : per-port request signature
//   rsp_valid_o/ready_i : per-port response handshake, valid only in RSP
//   rsp_sig_o           : signature of the completed pair, stable while valid
//   busy_lines_o        : number of occupied CAM lines
module fractal_sync_mp_rsp
  import fractal_sync_pkg::*;
#(
  parameter int unsigned SIG_WIDTH = 1,
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned N_LINES   = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_PORTS-1:0]                req_valid_i,
  input  logic [SIG_WIDTH-1:0]              req_sig_i [N_PORTS],
  output logic [N_PORTS-1:0]                req_ready_o,
  output logic [N_PORTS-1:0]                rsp_valid_o,
  output logic [SIG_WIDTH-1:0]              rsp_sig_o [N_PORTS],
  input  logic [N_PORTS-1:0]                rsp_ready_i,
  output logic [popcnt_width(N_LINES)-1:0]  busy_lines_o
);

  localparam int unsigned IDX_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_WIDTH = popcnt_width(N_LINES);

  fractal_sync_rsp_state_e state_q [N_PORTS];
  fractal_sync_rsp_state_e state_d [N_PORTS];
  logic [SIG_WIDTH-1:0]    rsp_sig_q [N_PORTS];
  logic [SIG_WIDTH-1:0]    rsp_sig_d [N_PORTS];

  logic [N_LINES-1:0]   line_valid;
  logic [IDX_WIDTH-1:0] line_origin [N_LINES];
  logic [N_PORTS-1:0]   line_match [N_LINES];
  logic [N_LINES-1:0]   line_alloc;
  logic [SIG_WIDTH-1:0] line_alloc_sig [N_LINES];
  logic [IDX_WIDTH-1:0] line_alloc_origin [N_LINES];
  logic [N_LINES-1:0]   line_consumed;

  logic [N_PORTS-1:0]   accepted;
  logic [N_PORTS-1:0]   paired;
  logic [N_PORTS-1:0]   allocated;
  logic [N_PORTS-1:0]   woken;
  logic [SIG_WIDTH-1:0] wake_sig [N_PORTS];
  logic                 alloc_fail;

  logic [CNT_WIDTH-1:0] busy_q;
  logic [CNT_WIDTH-1:0] busy_d;

  for (genvar l = 0; l < N_LINES; l++) begin : g_line
    fractal_sync_mp_rsp_line #(
      .SIG_WIDTH (SIG_WIDTH),
      .N_PORTS   (N_PORTS),
      .IDX_WIDTH (IDX_WIDTH)
    ) u_line (
      .clk          (clk_i),
      .rst_n        (rst_ni),
      .alloc        (line_alloc[l]),
      .alloc_sig    (line_alloc_sig[l]),
      .alloc_origin (line_alloc_origin[l]),
      .release_line (line_consumed[l]),
      .cmp_sig      (req_sig_i),
      .valid        (line_valid[l]),
      .origin       (line_origin[l]),
      .match        (line_match[l])
    );
  end

  fractal_sync_mp_rsp_chk #(
    .N_PORTS (N_PORTS),
    .N_LINES (N_LINES)
  ) u_chk (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .alloc_fail (alloc_fail)
  );

  // Match resolution. Pairing is decided first in ascending port order (CAM hit
  // on the lowest line, else the lowest still-unpaired earlier port); only the
  // ports left unpaired then take free lines, so a port that gets paired by a
  // later port in the same cycle never consumes a line.
  always_comb begin
    logic found;
    line_consumed = '0;
    line_alloc    = '0;
    paired        = '0;
    allocated     = '0;
    woken         = '0;
    alloc_fail    = 1'b0;
    found         = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      accepted[p] = req_valid_i[p] && (state_q[p] == IDLE);
      wake_sig[p] = '0;
    end
    for (int unsigned l = 0; l < N_LINES; l++) begin
      line_alloc_sig[l]    = '0;
      line_alloc_origin[l] = '0;
    end

    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (accepted[i]) begin
        for (int unsigned l = 0; l < N_LINES; l++) begin
          if (!paired[i] && line_valid[l] && !line_consumed[l] && line_match[l][i]) begin
            line_consumed[l]          = 1'b1;
            paired[i]                 = 1'b1;
            woken[line_origin[l]]     = 1'b1;
            wake_sig[line_origin[l]]  = req_sig_i[i];
          end else begin
            line_consumed[l] = line_consumed[l];
          end
        end
        for (int unsigned j = 0; j < N_PORTS; j++) begin
          if (!paired[i] && (j < i) && accepted[j] && !paired[j] &&
              (req_sig_i[j] == req_sig_i[i])) begin
            paired[i] = 1'b1;
            paired[j] = 1'b1;
          end else begin
            paired[i] = paired[i];
          end
        end
      end else begin
        paired[i] = 1'b0;
      end
    end

    // Lines that were valid at cycle start are never free here, so a line
    // released this cycle only becomes allocatable next cycle.
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (accepted[i] && !paired[i]) begin
        found = 1'b0;
        for (int unsigned l = 0; l < N_LINES; l++) begin
          if (!found && !line_valid[l] && !line_alloc[l]) begin
            line_alloc[l]        = 1'b1;
            line_alloc_sig[l]    = req_sig_i[i];
            line_alloc_origin[l] = IDX_WIDTH'(i);
            found                = 1'b1;
          end else begin
            found = found;
          end
        end
        allocated[i] = found;
        if (!found) begin
          alloc_fail = 1'b1;
        end else begin
          alloc_fail = alloc_fail;
        end
      end else begin
        allocated[i] = 1'b0;
      end
    end
  end

  // Per-port FSM next state and response signature capture.
  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      state_d[p]   = state_q[p];
      rsp_sig_d[p] = rsp_sig_q[p];
      case (state_q[p])
        IDLE: begin
          if (accepted[p] && paired[p]) begin
            state_d[p]   = RSP;
            rsp_sig_d[p] = req_sig_i[p];
          end else if (allocated[p]) begin
            state_d[p] = WAIT;
          end else begin
            state_d[p] = IDLE;
          end
        end
        WAIT: begin
          if (woken[p]) begin
            state_d[p]   = RSP;
            rsp_sig_d[p] = wake_sig[p];
          end else begin
            state_d[p] = WAIT;
          end
        end
        RSP: begin
          if (rsp_ready_i[p]) begin
            state_d[p] = IDLE;
          end else begin
            state_d[p] = RSP;
          end
        end
        default: begin
          state_d[p] = IDLE;
        end
      endcase
    end
  end

  // Occupancy after this edge: surviving lines plus fresh allocations.
  always_comb begin
    busy_d = '0;
    for (int unsigned l = 0; l < N_LINES; l++) begin
      if (line_alloc[l] || (line_valid[l] && !line_consumed[l])) begin
        busy_d = busy_d + CNT_WIDTH'(1'b1);
      end else begin
        busy_d = busy_d;
      end
    end
  end

  // State, response signature and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        state_q[p]   <= IDLE;
        rsp_sig_q[p] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        state_q[p]   <= state_d[p];
        rsp_sig_q[p] <= rsp_sig_d[p];
      end
      busy_q <= busy_d;
    end
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      req_ready_o[p] = (state_q[p] == IDLE);
      rsp_valid_o[p] = (state_q[p] == RSP);
      rsp_sig_o[p]   = rsp_sig_q[p];
    end
    busy_lines_o = busy_q;
  end

endmodule

// File: tb/tb_fractal_sync_mp_rsp.sv
module tb_fractal_sync_mp_rsp;

  localparam int NP = 4;
  localparam int NL = 4;
  localparam int SW = 4;

  logic          clk_i;
  logic          rst_ni;
  logic [NP-1:0] req_valid_i;
  logic [SW-1:0] req_sig_i [NP];
  logic [NP-1:0] req_ready_o;
  logic [NP-1:0] rsp_valid_o;
  logic [SW-1:0] rsp_sig_o [NP];
  logic [NP-1:0] rsp_ready_i;
  logic [2:0]    busy_lines_o;

  fractal_sync_mp_rsp #(
    .SIG_WIDTH (SW),
    .N_PORTS   (NP),
    .N_LINES   (NL)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_sig_i    (req_sig_i),
    .req_ready_o  (req_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_sig_o    (rsp_sig_o),
    .rsp_ready_i  (rsp_ready_i),
    .busy_lines_o (busy_lines_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 = free to request, 1 = parked, 2 = response pending.
  int         m_state [NP];
  logic [3:0] m_sig   [NP];
  int         m_park  [int];   // signature -> parked port

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_state[p] = 0;
      m_sig[p]   = 4'h0;
    end
    m_park.delete();
  endtask

  // Applies the pairing rules to the inputs that the next rising edge samples.
  task automatic model_update();
    int         st_n [NP];
    logic [3:0] sg_n [NP];
    bit         pend [NP];
    int         s;
    int         o;
    bit         found;
    for (int p = 0; p < NP; p++) begin
      st_n[p] = m_state[p];
      sg_n[p] = m_sig[p];
      pend[p] = 1'b0;
      if (m_state[p] == 2 && rsp_ready_i[p]) st_n[p] = 0;
    end
    for (int i = 0; i < NP; i++) begin
      if (req_valid_i[i] && m_state[i] == 0) begin
        s = int'(req_sig_i[i]);
        if (m_park.exists(s)) begin
          o = m_park[s];
          m_park.delete(s);
          st_n[o] = 2; sg_n[o] = req_sig_i[i];
          st_n[i] = 2; sg_n[i] = req_sig_i[i];
        end else begin
          found = 1'b0;
          for (int j = 0; j < i; j++) begin
            if (!found && pend[j] && req_sig_i[j] == req_sig_i[i]) begin
              found   = 1'b1;
              pend[j] = 1'b0;
              st_n[j] = 2; sg_n[j] = req_sig_i[i];
              st_n[i] = 2; sg_n[i] = req_sig_i[i];
            end
          end
          if (!found) pend[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (pend[i]) begin
        m_park[int'(req_sig_i[i])] = i;
        st_n[i] = 1;
      end
    end
    for (int p = 0; p < NP; p++) begin
      m_state[p] = st_n[p];
      m_sig[p]   = sg_n[p];
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("ready[%0d]", p), 32'(req_ready_o[p]), 32'(m_state[p] == 0));
      chk($sformatf("rsp_valid[%0d]", p), 32'(rsp_valid_o[p]), 32'(m_state[p] == 2));
      if (m_state[p] == 2) chk($sformatf("rsp_sig[%0d]", p), 32'(rsp_sig_o[p]), 32'(m_sig[p]));
    end
    chk("busy", 32'(busy_lines_o), 32'(m_park.num()));
  endtask

  // Called at a falling edge: drive, predict, wait one cycle, compare.
  task automatic drive(input logic [3:0] v, input logic [15:0] s, input logic [3:0] r);
    logic [15:0] sv;
    sv = s;
    req_valid_i = v;
    rsp_ready_i = r;
    for (int p = 0; p < NP; p++) req_sig_i[p] = sv[4*p +: 4];
    model_update();
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    for (int p = 0; p < NP; p++) req_sig_i[p] = 4'h0;
    model_reset();
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'hF);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_lines_o), 32'h0);
    for (int p = 0; p < NP; p++) chk($sformatf("rst_rsp_sig[%0d]", p), 32'(rsp_sig_o[p]), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_outputs();
  endtask

  logic [3:0] held_sig;
  logic [15:0] rs;

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    for (int p = 0; p < NP; p++) req_sig_i[p] = 4'h0;
    @(negedge clk_i);
    do_reset();

    // Park on port 0, complete from port 3 three cycles later.
    drive(4'b0001, 16'h0005, 4'hF);
    chk("park_busy", 32'(busy_lines_o), 32'd1);
    drive(4'b0000, 16'h0000, 4'hF);
    drive(4'b0000, 16'h0000, 4'hF);
    drive(4'b1000, 16'h5000, 4'hF);
    chk("pair_valid", 32'(rsp_valid_o), 32'b1001);
    chk("pair_busy", 32'(busy_lines_o), 32'd0);
    drive(4'b0000, 16'h0000, 4'hF);

    // Same-cycle direct pair.
    drive(4'b0110, 16'h0AA0, 4'hF);
    chk("direct_valid", 32'(rsp_valid_o), 32'b0110);
    drive(4'b0000, 16'h0000, 4'hF);

    // Three equal: 0,1 pair, 2 parks; then 3 completes with 2.
    drive(4'b0111, 16'h0777, 4'hF);
    chk("three_valid", 32'(rsp_valid_o), 32'b0011);
    chk("three_busy", 32'(busy_lines_o), 32'd1);
    drive(4'b1000, 16'h7000, 4'hF);
    chk("three_late_valid", 32'(rsp_valid_o), 32'b1100);
    drive(4'b0000, 16'h0000, 4'hF);

    // Response backpressure on port 0.
    drive(4'b0011, 16'h0033, 4'b1110);
    held_sig = rsp_sig_o[0];
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 16'h0009, 4'b1110);
      chk("bp_sig_stable", 32'(rsp_sig_o[0]), 32'h3);
      chk("bp_sig_held", 32'(rsp_sig_o[0]), 32'(held_sig));
    end
    drive(4'b0000, 16'h0000, 4'hF);
    chk("bp_released", 32'(req_ready_o[0]), 32'd1);

    // Fill all lines, port 0 stays blocked, then reset with ports parked.
    drive(4'b1111, 16'h4321, 4'hF);
    chk("fill_busy", 32'(busy_lines_o), 32'd4);
    drive(4'b0001, 16'h0001, 4'hF);
    drive(4'b0000, 16'h0000, 4'hF);
    do_reset();
    drive(4'b0000, 16'h0000, 4'hF);

    // Randomized traffic with a small signature space to provoke matches.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      for (int p = 0; p < NP; p++) rs[4*p +: 4] = 4'($urandom_range(0, 3));
      drive(4'($urandom_range(0, 15)), rs,
            {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fractal_sync_mp_rsp.md
Name: fractal_sync_mp_rsp

Overview:
- Multi-port pairwise synchronization responder: the response side of the fractal sync multi-port CAM protocol.
- Each port issues a sync request carrying a signature. The first arrival for a signature is parked in a CAM line together with its originating port index. The second arrival with the same signature completes the pair, frees the line and sends a response to both participants.
- Sits in a fractal sync tree node, between the per-port request links and the wake/response links back to the requesters.

Parameters:
- SIG_WIDTH, 1, signature width in bits.
- N_PORTS, 2, number of request/response ports; must be >= 2.
- N_LINES, 2, number of CAM lines; elaboration-time fatal assertion requires N_LINES >= N_PORTS.
- Localparam IDX_WIDTH = max(1, $clog2(N_PORTS)).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1 [N_PORTS]  request valid per port.
- req_sig_i  in  SIG_WIDTH [N_PORTS]  request signature.
- req_ready_o  out  1 [N_PORTS]  request accepted on valid & ready.
- rsp_valid_o  out  1 [N_PORTS]  response valid.
- rsp_sig_o  out  SIG_WIDTH [N_PORTS]  signature of the completed pair.
- rsp_ready_i  in  1 [N_PORTS]  response consumed on valid & ready.
- busy_lines_o  out  $clog2(N_LINES+1)  number of occupied CAM lines.

Behaviour:
- Reset (asynchronous, active-low):
  - all lines invalid; line sig and origin regs cleared to 0;
  - all port FSMs to IDLE;
  - outputs: req_ready_o=1, rsp_valid_o=0, rsp_sig_o=0, busy_lines_o=0.
  - Reset mid-operation discards all parked requests and undelivered responses. No response is ever issued for them.
- Per-port FSM states: IDLE, WAIT, RSP.
  - req_ready_o[i] = (state==IDLE). It is registered-state only and never depends on req_valid_i.
  - IDLE -> WAIT: request accepted and no match; a line is allocated.
  - IDLE -> RSP: request accepted and matched.
  - WAIT -> RSP: another port's request matches this port's parked line.
  - RSP -> IDLE: rsp_valid_o & rsp_ready_i.
  - rsp_valid_o[i] = (state==RSP). rsp_sig_o[i] is registered and held stable while valid.
- Match resolution is combinational and processed in ascending port index within a cycle. An accepted request on port i, in order:
  1. If a valid line holds an equal sig (lowest line index first): the line is invalidated next edge, the origin port goes WAIT->RSP and port i goes IDLE->RSP. Both rsp_sig = sig.
  2. Else, if a lower-index port accepted this cycle with an equal sig and is still unpaired: the two pair directly. Both go to RSP and no line is allocated.
  3. Else: allocate the lowest-index free line (free at cycle start and not allocated earlier this cycle), storing sig and origin=i. Port i goes to WAIT.
- Latency: a completing request accepted at edge t gives rsp_valid_o high for both participants after edge t (visible in cycle t+1).
- A line freed in cycle t is reusable from cycle t+1 only. Same-cycle free-and-reallocate is forbidden.
- Capacity: each port has at most one outstanding request and N_LINES >= N_PORTS, so allocation never fails.
  - An allocation attempt with no free line is a simulation assertion error.
  - The RTL then drops the request and leaves the port in IDLE.
- Three or more same-cycle equal sigs pair in index order. Example: ports 0,1,2 equal, no line present → 0 and 1 pair, 2 is parked.
- A port in WAIT or RSP never matches itself (req_ready_o=0 blocks it).
- busy_lines_o = popcount of valid lines, registered.

Decomposition:
- fractal_sync_pkg gets:
  - typedef fractal_sync_rsp_state_e {IDLE, WAIT, RSP};
  - a helper function for the popcount width.
- One sub-module, fractal_sync_mp_rsp_line:
  - holds valid, sig, origin;
  - inputs: alloc, alloc_sig, alloc_origin, release;
  - outputs: valid, origin, and per-port match[N_PORTS] (sig equality & valid).
- The top holds the port FSMs, the priority resolution loop and the response registers.

Test Plan:
- Reset with SIG_WIDTH=4, N_PORTS=4, N_LINES=4 → req_ready_o all 1, rsp_valid_o all 0, busy_lines_o=0. Assert rst_ni low while port 2 is in WAIT → port 2 back to IDLE and busy=0, with no response.
- Port 0 sends sig 0x5 at t; port 3 sends 0x5 at t+3 → port 0 ready=0 from t+1, busy=1 during t+1..t+3. At t+4 rsp_valid_o[0]=rsp_valid_o[3]=1 with rsp_sig=0x5 and busy=0.
- Ports 1 and 2 send 0xA in the same cycle with the CAM empty → both respond next cycle and busy_lines_o stays 0.
- Ports 0,1,2 send 0x7 in the same cycle → ports 0,1 respond next cycle, port 2 goes to WAIT with busy=1. Port 3 then sends 0x7 → ports 2,3 respond.
- Response backpressure: hold rsp_ready_i[0]=0 for 5 cycles after a completion → rsp_valid_o[0] and rsp_sig_o[0] are stable and req_ready_o[0]=0. Release → IDLE on the next cycle.
- Fill: 4 ports send distinct sigs 1,2,3,4 → busy=4 and no responses. Port 0 (WAIT) stays blocked; the assertion does not fire.
